// File: rtl/div_sched.sv
// div_sched -- operand scheduler placed directly in front of a sequential
// fixed-point divider that has a synchronous active-high rst and a
// complete output.
//
// Operand pairs (a, b) are buffered in a DEPTH-entry FIFO. Pairs are issued
// to the divider one at a time. The divider operands are held in registers
// for the whole operation, and the divider rst is sequenced to start and
// clear each division. Quotients return in push order through a
// valid/ready result slot. Pairs with b == 0 never reach the divider: they
// produce out_q = 0 with out_dz = 1.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   in_valid/in_ready/in_a/in_b       operand push port
//   out_valid/out_ready/out_q/out_dz  result port
//   div_rst       divider reset, active high (1 whenever not in RUN)
//   div_a/div_b   divider operands, registered
//   div_complete  divider done strobe/level
//   div_out       divider quotient
//   div_timeout   sticky watchdog flag
//
// Optional feature: define DIV_SCHED_TIMEOUT_EN to add a RUN-state watchdog.
// When the watchdog reaches TIMEOUT cycles without div_complete, it raises
// div_timeout (sticky), returns a zero result and moves on to the next pair.
// Without the macro, div_timeout is tied low and RUN waits indefinitely.
module div_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  out_dz,
  output logic                  div_rst,
  output logic [DATA_WIDTH-1:0] div_a,
  output logic [DATA_WIDTH-1:0] div_b,
  input  logic                  div_complete,
  input  logic [DATA_WIDTH-1:0] div_out,
  output logic                  div_timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT <= 2 * DATA_WIDTH) begin : g_param_check
    $error("div_sched: DEPTH must be a power of two >= 2 and TIMEOUT > 2*DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CLEAR
  } state_t;

  // ---------------------------------------------------------------------
  // Operand FIFO
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem_a [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head_a;
  logic [DATA_WIDTH-1:0] w_head_b;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && !w_full;
  assign in_ready = !w_full;
  assign w_head_a = r_mem_a[r_rd_ptr];
  assign w_head_b = r_mem_b[r_rd_ptr];

  // Storage carries no reset; occupancy is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Issue state machine
  // ---------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;

  logic                  r_byp_pend;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_q;
  logic                  r_out_dz;
  logic [DATA_WIDTH-1:0] r_div_a;
  logic [DATA_WIDTH-1:0] r_div_b;

  logic w_slot_free;
  logic w_issue;
  logic w_byp;
  logic w_capture;
  logic w_tmo;
  logic w_div_rst;

  // The slot counts as free when it is empty or is being emptied this cycle.
  assign w_slot_free = !r_out_valid || out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_byp       = 1'b0;
    w_capture   = 1'b0;
    w_div_rst   = 1'b1;
    case (r_state)
      S_IDLE: begin
        // A pending bypass result still owns the slot for one more cycle.
        if (!w_empty && !r_byp_pend && w_slot_free) begin
          w_pop = 1'b1;
          if (w_head_b == '0) begin
            w_byp = 1'b1;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_div_rst = 1'b0;
        if (div_complete) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CLEAR;
        end else if (w_tmo) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // div_rst is decoded from the state register, so an asynchronous reset
  // forces it high immediately through the return to IDLE.
  assign div_rst = w_div_rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_byp_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byp_pend <= w_byp;
    end
  end

  // Operands are captured only on issue and stay put through LOAD/RUN/CLEAR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_a <= '0;
      r_div_b <= '0;
    end else if (w_issue) begin
      r_div_a <= w_head_a;
      r_div_b <= w_head_b;
    end
  end

  assign div_a = r_div_a;
  assign div_b = r_div_b;

  // ---------------------------------------------------------------------
  // Result slot
  // ---------------------------------------------------------------------
  // A result is loaded only after a pop that found the slot free, so a load
  // never overwrites a result that is still waiting for out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_dz    <= 1'b0;
    end else if (r_byp_pend) begin
      r_out_valid <= 1'b1;
      r_out_q     <= '0;
      r_out_dz    <= 1'b1;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_q     <= div_out;
      r_out_dz    <= 1'b0;
    end else if (w_tmo) begin
      r_out_valid <= 1'b1;
      r_out_q     <= '0;
      r_out_dz    <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
  assign out_dz    = r_out_dz;

  // ---------------------------------------------------------------------
  // Optional RUN watchdog
  // ---------------------------------------------------------------------
`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] r_tcnt;
  logic          r_timeout;

  // The counter holds the number of completed RUN cycles. It fires on the
  // TIMEOUT-th RUN cycle and restarts from zero outside RUN.
  assign w_tmo = (r_state == S_RUN) && !div_complete && (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tcnt <= (r_state == S_RUN && !w_tmo) ? r_tcnt + TW'(1) : '0;
      if (w_tmo) r_timeout <= 1'b1;
    end
  end

  assign div_timeout = r_timeout;
`else
  assign w_tmo       = 1'b0;
  assign div_timeout = 1'b0;
`endif

endmodule
